// File: rtl/hazard_interlock_pkg.sv
// Shared pipeline definitions for the ID-stage hazard interlock.
// Provides the register-index width, the scoreboard slot layout and the zero register.
package hazard_interlock_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic              valid;
    logic              rw;
    logic              memread;
    logic [REG_AW-1:0] rd;
  } slot_t;

endpackage

// File: rtl/hazard_slot_match.sv
// Combinational producer match for one scoreboard slot against the ID-stage sources.
// Register 0 never matches, so it can never raise a dependency.
module hazard_slot_match
  import hazard_interlock_pkg::*;
(
  input  slot_t             slot,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              use_rs,
  input  logic              use_rt,
  output logic              hit
);

  logic produces;
  logic match_rs;
  logic match_rt;

  always_comb begin
    produces = slot.valid && slot.rw && (slot.rd != ZERO_REG);
    match_rs = produces && (slot.rd == rs);
    match_rt = produces && (slot.rd == rt);
    hit      = (use_rs && match_rs) || (use_rt && match_rt);
  end

endmodule

// File: rtl/hazard_interlock.sv
// ID-stage interlock: shadow scoreboard of EX/MEM producers driving stall, flush and freeze.
// Optional saturating statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_interlock #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned STAT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] IFID_rs_i,
  input  logic [REG_AW-1:0] IFID_rt_i,
  input  logic              ID_use_rs_i,
  input  logic              ID_use_rt_i,
  input  logic              ID_rw_i,
  input  logic [REG_AW-1:0] ID_rd_i,
  input  logic              ID_memread_i,
  input  logic              ID_branch_i,
  input  logic              branch_taken_i,
  input  logic              mem_stall_i,
  output logic              PC_write_o,
  output logic              IFID_write_o,
  output logic              IFID_flush_o,
  output logic              IDEX_bubble_o,
  output logic              freeze_o,
  output logic [STAT_W-1:0] stall_cycles_o,
  output logic [STAT_W-1:0] flush_count_o
);

  import hazard_interlock_pkg::slot_t;

  slot_t ex_q;
  slot_t mem_q;
  logic  ex_hit;
  logic  mem_hit;
  logic  haz;

  hazard_slot_match u_ex_match (
    .slot   (ex_q),
    .rs     (IFID_rs_i),
    .rt     (IFID_rt_i),
    .use_rs (ID_use_rs_i),
    .use_rt (ID_use_rt_i),
    .hit    (ex_hit)
  );

  hazard_slot_match u_mem_match (
    .slot   (mem_q),
    .rs     (IFID_rs_i),
    .rt     (IFID_rt_i),
    .use_rs (ID_use_rs_i),
    .use_rt (ID_use_rt_i),
    .hit    (mem_hit)
  );

  // A branch waiting on a load in MEM only needs this term once EX no longer covers it.
  always_comb begin
    haz = (ex_hit && ex_q.memread)
       || (ID_branch_i && ex_hit)
       || (ID_branch_i && !ex_hit && mem_q.memread && mem_hit);
  end

  always_comb begin
    PC_write_o    = 1'b0;
    IFID_write_o  = 1'b0;
    IFID_flush_o  = 1'b0;
    IDEX_bubble_o = 1'b0;
    freeze_o      = 1'b0;
    if (!rst_i) begin
      IDEX_bubble_o = 1'b1;
    end else if (mem_stall_i) begin
      freeze_o = 1'b1;
    end else if (haz) begin
      IDEX_bubble_o = 1'b1;
    end else begin
      PC_write_o   = 1'b1;
      IFID_write_o = 1'b1;
      IFID_flush_o = ID_branch_i && branch_taken_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else if (!mem_stall_i) begin
      mem_q <= ex_q;
      if (haz) begin
        ex_q <= '0;
      end else begin
        ex_q.valid   <= 1'b1;
        ex_q.rw      <= ID_rw_i;
        ex_q.memread <= ID_memread_i;
        ex_q.rd      <= ID_rd_i;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q;
  logic [STAT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (haz && !mem_stall_i && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      end
      if (IFID_flush_o && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + STAT_W'(1);
      end
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_interlock.sv
// Directed self-checking bench for hazard_interlock.
// Output vector order: {PC_write, IFID_write, IFID_flush, IDEX_bubble, freeze}.
module tb_hazard_interlock;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned STAT_W = 32;

  localparam logic [4:0] RUN       = 5'b11000;
  localparam logic [4:0] RUN_FLUSH = 5'b11100;
  localparam logic [4:0] STALL     = 5'b00010;
  localparam logic [4:0] FREEZE    = 5'b00001;
  localparam logic [4:0] RST_OUT   = 5'b00010;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [REG_AW-1:0] IFID_rs_i;
  logic [REG_AW-1:0] IFID_rt_i;
  logic              ID_use_rs_i;
  logic              ID_use_rt_i;
  logic              ID_rw_i;
  logic [REG_AW-1:0] ID_rd_i;
  logic              ID_memread_i;
  logic              ID_branch_i;
  logic              branch_taken_i;
  logic              mem_stall_i;
  logic              PC_write_o;
  logic              IFID_write_o;
  logic              IFID_flush_o;
  logic              IDEX_bubble_o;
  logic              freeze_o;
  logic [STAT_W-1:0] stall_cycles_o;
  logic [STAT_W-1:0] flush_count_o;
  logic [4:0]        obs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign obs = {PC_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o, freeze_o};

  hazard_interlock #(.REG_AW(REG_AW), .STAT_W(STAT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .IFID_rs_i      (IFID_rs_i),
    .IFID_rt_i      (IFID_rt_i),
    .ID_use_rs_i    (ID_use_rs_i),
    .ID_use_rt_i    (ID_use_rt_i),
    .ID_rw_i        (ID_rw_i),
    .ID_rd_i        (ID_rd_i),
    .ID_memread_i   (ID_memread_i),
    .ID_branch_i    (ID_branch_i),
    .branch_taken_i (branch_taken_i),
    .mem_stall_i    (mem_stall_i),
    .PC_write_o     (PC_write_o),
    .IFID_write_o   (IFID_write_o),
    .IFID_flush_o   (IFID_flush_o),
    .IDEX_bubble_o  (IDEX_bubble_o),
    .freeze_o       (freeze_o),
    .stall_cycles_o (stall_cycles_o),
    .flush_count_o  (flush_count_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                       input logic urt, input logic rw, input logic [4:0] rd,
                       input logic mr, input logic br, input logic tk, input logic ms);
    IFID_rs_i      = rs;
    IFID_rt_i      = rt;
    ID_use_rs_i    = urs;
    ID_use_rt_i    = urt;
    ID_rw_i        = rw;
    ID_rd_i        = rd;
    ID_memread_i   = mr;
    ID_branch_i    = br;
    branch_taken_i = tk;
    mem_stall_i    = ms;
    #2;
  endtask

  task automatic drain();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== RST_OUT) begin
      errors++;
      $display("FAIL reset_forced: got %b expected %b", obs, RST_OUT);
    end
    step();
    step();
    rst_i = 1'b1;
    #1;
    checks++;
    if (obs !== RUN) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", obs, RUN);
    end
    step();
  endtask

  task automatic test_load_use();
    drive(5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== RUN) begin
      errors++;
      $display("FAIL load_use_lw: got %b expected %b", obs, RUN);
    end
    step();
    drive(5'd8, 1'b1, 5'd3, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== STALL) begin
      errors++;
      $display("FAIL load_use_stall: got %b expected %b", obs, STALL);
    end
    step();
    checks++;
    if (obs !== RUN) begin
      errors++;
      $display("FAIL load_use_resume: got %b expected %b", obs, RUN);
    end
    step();
    drain();
  endtask

  task automatic test_branch_alu();
    drive(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd4, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== STALL) begin
      errors++;
      $display("FAIL branch_alu_stall: got %b expected %b", obs, STALL);
    end
    step();
    checks++;
    if (obs !== RUN) begin
      errors++;
      $display("FAIL branch_alu_resume: got %b expected %b", obs, RUN);
    end
    step();
    drain();
  endtask

  task automatic test_branch_load();
    drive(5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd4, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== STALL) begin
      errors++;
      $display("FAIL branch_load_stall1: got %b expected %b", obs, STALL);
    end
    step();
    checks++;
    if (obs !== STALL) begin
      errors++;
      $display("FAIL branch_load_stall2: got %b expected %b", obs, STALL);
    end
    step();
    checks++;
    if (obs !== RUN) begin
      errors++;
      $display("FAIL branch_load_resume: got %b expected %b", obs, RUN);
    end
    step();
    drain();
  endtask

  task automatic test_taken_branch();
    drive(5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs !== RUN_FLUSH) begin
      errors++;
      $display("FAIL taken_flush: got %b expected %b", obs, RUN_FLUSH);
    end
    step();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== RUN) begin
      errors++;
      $display("FAIL taken_flush_once: got %b expected %b", obs, RUN);
    end
`ifdef HAZARD_STATS_EN
    checks++;
    if (flush_count_o !== 32'd1) begin
      errors++;
      $display("FAIL flush_count: got %0d expected %0d", flush_count_o, 1);
    end
`endif
    step();
    drain();
  endtask

  task automatic test_mem_stall();
    drive(5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs !== FREEZE) begin
        errors++;
        $display("FAIL mem_stall_freeze%0d: got %b expected %b", i, obs, FREEZE);
      end
      step();
    end
    drive(5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== STALL) begin
      errors++;
      $display("FAIL mem_stall_then_stall: got %b expected %b", obs, STALL);
    end
    step();
    checks++;
    if (obs !== RUN) begin
      errors++;
      $display("FAIL mem_stall_resume: got %b expected %b", obs, RUN);
    end
    step();
    drain();
  endtask

  task automatic test_reg_zero();
    drive(5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== RUN) begin
      errors++;
      $display("FAIL reg_zero_no_stall: got %b expected %b", obs, RUN);
    end
    step();
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drive(5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd4, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== STALL) begin
      errors++;
      $display("FAIL mid_stall_first: got %b expected %b", obs, STALL);
    end
    step();
    rst_i = 1'b0;
    #1;
    checks++;
    if (obs !== RST_OUT) begin
      errors++;
      $display("FAIL mid_stall_forced: got %b expected %b", obs, RST_OUT);
    end
    step();
    rst_i = 1'b1;
    #1;
    checks++;
    if (obs !== RUN) begin
      errors++;
      $display("FAIL mid_stall_release: got %b expected %b", obs, RUN);
    end
`ifdef HAZARD_STATS_EN
    checks++;
    if (stall_cycles_o !== 32'd0) begin
      errors++;
      $display("FAIL stall_cycles_cleared: got %0d expected %0d", stall_cycles_o, 0);
    end
`endif
    step();
    drain();
  endtask

  task automatic test_stats_ports();
`ifdef HAZARD_STATS_EN
    // One stall from the fresh load-use pair after the mid-stall reset.
    drive(5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 5'd13, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checks++;
    if (stall_cycles_o !== 32'd1) begin
      errors++;
      $display("FAIL stall_cycles_count: got %0d expected %0d", stall_cycles_o, 1);
    end
    drain();
`else
    checks++;
    if (stall_cycles_o !== '0) begin
      errors++;
      $display("FAIL stall_cycles_tied: got %0d expected %0d", stall_cycles_o, 0);
    end
    checks++;
    if (flush_count_o !== '0) begin
      errors++;
      $display("FAIL flush_count_tied: got %0d expected %0d", flush_count_o, 0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_alu();
    test_branch_load();
    test_taken_branch();
    test_mem_stall();
    test_reg_zero();
    test_reset_mid_stall();
    test_stats_ports();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_interlock.md
Name: hazard_interlock

Overview:
ID-stage interlock for the 5-stage pipeline. It is the complement of the EX-stage forwarding unit: forwarding delivers producer results back to EX, and this block stalls or flushes the front end when forwarding cannot cover a dependency. It keeps its own shadow scoreboard of the instructions in EX and MEM, so it needs only ID-stage inputs. It drives PC write, IF/ID write and flush, the ID/EX bubble, and a pipeline freeze.

Parameters:
REG_AW, 5, register-index width
STAT_W, 32, width of the statistics counters (optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-low
IFID_rs_i  in  REG_AW  source register rs of the instruction in ID
IFID_rt_i  in  REG_AW  source register rt of the instruction in ID
ID_use_rs_i  in  1  ID instruction reads rs
ID_use_rt_i  in  1  ID instruction reads rt
ID_rw_i  in  1  ID instruction writes a register
ID_rd_i  in  REG_AW  destination register of the ID instruction
ID_memread_i  in  1  ID instruction is a load
ID_branch_i  in  1  ID instruction is a branch compared in ID
branch_taken_i  in  1  ID branch comparison result
mem_stall_i  in  1  data memory busy
PC_write_o  out  1  PC update enable
IFID_write_o  out  1  IF/ID register load enable
IFID_flush_o  out  1  zero the IF/ID register
IDEX_bubble_o  out  1  load a NOP into ID/EX
freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB
stall_cycles_o  out  STAT_W  hazard-stall cycle count (optional feature)
flush_count_o  out  STAT_W  taken-branch flush count (optional feature)

Behaviour:
- Scoreboard: two slots, EX and MEM. Each slot holds {valid, rw, memread, rd}. Reset (rst_i low, asynchronous) sets every field to 0.
- Match(slot, r) is true when slot.valid && slot.rw && slot.rd != 0 && slot.rd == r.
- Used-source hit: (ID_use_rs_i && Match(slot, IFID_rs_i)) || (ID_use_rt_i && Match(slot, IFID_rt_i)).
- Hazard stall (haz) is asserted when any of these hold:
  - Load-use: EX.memread && used-source hit on EX.
  - Branch on ALU result: ID_branch_i && used-source hit on EX, for any producer.
  - Branch on load data: ID_branch_i && EX clear && MEM.memread && used-source hit on MEM.
- A branch that depends on a load in EX therefore stalls 2 consecutive cycles. That is the natural result of the slots advancing; no counter is involved.
- Output decode is combinational from the slots and the ID inputs, evaluated in priority order:
  - mem_stall_i=1: freeze_o=1, PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=0, IFID_flush_o=0. Slots hold.
  - else haz=1: PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1, freeze_o=0, IFID_flush_o=0. On the next edge EX gets a bubble (valid=0) and MEM<=EX.
  - else: PC_write_o=1, IFID_write_o=1, IDEX_bubble_o=0, freeze_o=0, IFID_flush_o=ID_branch_i && branch_taken_i. On the next edge EX<={1, ID_rw_i, ID_memread_i, ID_rd_i} and MEM<=EX.
- A flush discards only the instruction in IF. The branch itself still issues into EX.
- While rst_i is low, outputs are forced: PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1, IFID_flush_o=0, freeze_o=0.
- After reset releases, outputs follow the priority decode above; with empty slots this gives PC_write_o=1, IFID_write_o=1.
- Register 0 never creates a hazard.
- A dependency on an instruction older than MEM is never a hazard; forwarding or the register file covers it.
- Reset mid-stall clears the slots, so no stall is pending after release.

Optional Feature:
HAZARD_STATS_EN
- Defined: two saturating counters of width STAT_W, both reset to 0.
  - stall_cycles_o increments in every cycle where haz=1 and mem_stall_i=0.
  - flush_count_o increments in every cycle where IFID_flush_o=1.
  - Both hold at all-ones once saturated.
- Undefined: the counters are not built and both ports are tied to 0.

Decomposition:
- Shared pipeline package:
  - REG_AW constant.
  - Slot struct typedef {valid, rw, memread, rd}.
  - ZERO_REG constant.
- One sub-module, hazard_slot_match: combinational Match plus used-source hit for one slot. It is instantiated once each for EX and MEM.

Test Plan:
- Load-use: issue lw rd=8, then add with rs=8 → one cycle of PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1; the following cycle PC_write_o=1.
- Branch after ALU: add rd=9, then beq with rt=9 → 1 stall cycle.
- Branch after load: lw rd=9, then beq with rt=9 → 2 stall cycles, after which no stall.
- Taken branch with no hazard: ID_branch_i=1, branch_taken_i=1 → IFID_flush_o=1 for exactly 1 cycle; PC_write_o=1.
- Memory stall during a hazard: mem_stall_i=1 for 3 cycles while a load-use hazard is pending → freeze_o=1 and IDEX_bubble_o=0 for those 3 cycles; the single load-use stall cycle (IDEX_bubble_o=1) follows once mem_stall_i drops.
- Register 0 and reset:
  - lw rd=0, then add with rs=0 → no stall.
  - Assert rst_i low during a 2-cycle branch stall → outputs forced immediately; after release, no stall and stall_cycles_o=0 (HAZARD_STATS_EN defined).
